prog_loader: RTL
================

Name: prog_loader

Overview:
- Program-load and instruction-memory front end that sits directly upstream of the fetch stage.
- Accepts a byte stream over a valid/ready handshake and writes it into an internal byte-addressed instruction memory.
- Releases the SEQ core with cpu_run once loading completes, then serves the 10-byte instruction window at PC to fetch.
- Stops the core when it reports a non-AOK status.

Parameters:
- ADDR_W, 10, instruction memory address width.
- MEM_BYTES, 2**ADDR_W, memory size in bytes; must be at least 10.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start  in  1  request a new program load.
- ld_valid  in  1  ld_data beat is valid.
- ld_data  in  8  program byte.
- ld_last  in  1  marks the final byte of the program.
- ld_ready  out  1  loader accepts a beat this cycle.
- pc  in  64  fetch address from the PC-update path.
- instr  out  80  bytes mem[pc..pc+9]; byte k occupies bits [8k+7:8k], so byte 0 (icode/ifun) is [7:0].
- imem_error  out  1  high when pc >= MEM_BYTES.
- cpu_stat  in  2  core status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- cpu_run  out  1  core enable.
- load_count  out  ADDR_W+1  number of bytes accepted in the current load.
- ld_overflow  out  1  sticky; program exceeded MEM_BYTES.
- state  out  2  IDLE=0, LOAD=1, RUN=2, STOP=3.

Behaviour:
- Reset state: state=IDLE, ld_ready=0, cpu_run=0, load_count=0, ld_overflow=0. Memory array is not cleared.
- ld_ready = (state==LOAD). cpu_run = (state==RUN). Both are decoded from the registered state, so there are no combinational paths from inputs.
- IDLE:
  - ld_start=1 -> LOAD next cycle; load_count<=0.
- LOAD:
  - Beat accepted when ld_valid && ld_ready.
  - If load_count < MEM_BYTES: mem[load_count]<=ld_data and load_count++.
  - Accepted beat with ld_last=1 -> RUN next cycle; that beat is still written.
  - Accepted beat with load_count==MEM_BYTES: data dropped, ld_overflow<=1, -> STOP. Overflow takes priority over ld_last.
  - ld_start is ignored in LOAD.
  - ld_valid=0 holds state; no timeout.
- RUN:
  - cpu_stat != 0 sampled -> STOP next cycle, so cpu_run drops one cycle after the status is seen.
  - ld_start is ignored.
  - Beats are not accepted (ld_ready=0).
- STOP:
  - ld_start -> LOAD; load_count<=0 and ld_overflow<=0.
  - Otherwise holds state.
- Read path: combinational, valid in every state.
  - For each k in 0..9 with address a=pc+k: byte = mem[a] if a < load_count, else 8'h00.
  - Unloaded bytes therefore decode as halt.
  - Address arithmetic is 64-bit with no wrap: any a >= MEM_BYTES reads 8'h00.
  - imem_error = (pc >= MEM_BYTES), compared on the full 64 bits. Fetch ORs it into its mem_error.
- Reset during LOAD or RUN:
  - Returns to IDLE the next edge with load_count=0.
  - Stale memory contents are masked by the load_count rule.
- Simultaneous rst with any other input: rst wins.
- load_count is ADDR_W+1 bits so it can represent MEM_BYTES without wrapping.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes STAT_AOK/HLT/ADR/INS.
  - loader state encodings LD_IDLE/LD_LOAD/LD_RUN/LD_STOP.
  - icode constants (I_HALT=0 ... I_POPQ=11).
  - INSTR_BYTES=10.
- One sub-module, imem_window: the 10-byte masked read mux (pc, load_count, memory read ports -> instr, imem_error).
- The FSM and write port stay in prog_loader.

Test Plan:
- Basic load and release: rst, ld_start, then stream 30 F0 0A 00 00 00 00 00 00 00 00 with ld_last on the 11th byte, pc=0 -> load_count=11, state RUN one cycle after the last beat, cpu_run=1, instr=80'h00_000000000000000A_F0_30.
- Masking of unloaded bytes: load 2 bytes 10 10 with ld_last, pc=0 -> instr[15:0]=16'h1010 and all higher bytes 00. Then pc=2 -> instr=0, imem_error=0.
- Status stop and reload: in RUN drive cpu_stat=1 -> state STOP next cycle and cpu_run=0. Then ld_start -> state LOAD, load_count=0.
- Overflow: with MEM_BYTES=16, stream 17 beats with no ld_last -> first 16 written, 17th dropped, ld_overflow=1, state STOP, load_count=16.
- Memory-end boundary: pc=MEM_BYTES-1 -> imem_error=0 and instr[7:0]=mem[last] if loaded, upper 9 bytes 00. pc=MEM_BYTES -> imem_error=1. pc=64'hFFFF_FFFF_FFFF_FFFF -> imem_error=1, instr=0.
- Reset and stall during LOAD: assert rst after 5 beats -> IDLE, load_count=0, ld_ready=0 next cycle, and instr reads 0 at pc=0. Separately, hold ld_valid=0 for 20 cycles in LOAD -> state and load_count unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, loader states, icodes and the fetch window size.
package y86_pkg;

  localparam int unsigned INSTR_BYTES = 10;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_RUN  = 2'd2,
    LD_STOP = 2'd3
  } ld_state_e;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

endpackage

// File: rtl/imem_window.sv
// Ten-byte instruction window at pc; bytes at or beyond load_count read as halt (8'h00).
module imem_window
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_BYTES = 2**ADDR_W
) (
  input  logic [63:0]                pc,
  input  logic [ADDR_W:0]            load_count,
  input  logic [7:0]                 mem [MEM_BYTES],
  output logic [INSTR_BYTES*8-1:0]   instr,
  output logic                       imem_error
);

  // 65-bit sum so pc+k near the top of the address space cannot wrap into loaded memory
  for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_byte
    logic [64:0] addr;
    assign addr = {1'b0, pc} + 65'(k);
    assign instr[8*k +: 8] = (addr < 65'(load_count)) ? mem[addr[ADDR_W-1:0]] : 8'h00;
  end

  assign imem_error = (pc >= 64'(MEM_BYTES));

endmodule

// File: rtl/prog_loader.sv
// Program loader FSM and instruction memory write port; releases the core once loading completes.
module prog_loader
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_BYTES = 2**ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_start,
  input  logic                      ld_valid,
  input  logic [7:0]                ld_data,
  input  logic                      ld_last,
  output logic                      ld_ready,
  input  logic [63:0]               pc,
  output logic [INSTR_BYTES*8-1:0]  instr,
  output logic                      imem_error,
  input  logic [1:0]                cpu_stat,
  output logic                      cpu_run,
  output logic [ADDR_W:0]           load_count,
  output logic                      ld_overflow,
  output logic [1:0]                state
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);

  ld_state_e       state_q, state_nx;
  logic [ADDR_W:0] count_nx;
  logic            ovf_nx;
  logic            wr_en;
  logic [7:0]      mem [MEM_BYTES];

  always_comb begin
    state_nx = state_q;
    count_nx = load_count;
    ovf_nx   = ld_overflow;
    wr_en    = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (ld_start) begin
          state_nx = LD_LOAD;
          count_nx = '0;
        end
      end
      LD_LOAD: begin
        // ld_ready is high throughout LOAD, so ld_valid alone accepts a beat
        if (ld_valid) begin
          if (load_count == FULL_COUNT) begin
            ovf_nx   = 1'b1;
            state_nx = LD_STOP;
          end else begin
            wr_en    = 1'b1;
            count_nx = (ADDR_W+1)'(load_count + 1'b1);
            if (ld_last) state_nx = LD_RUN;
          end
        end
      end
      LD_RUN: begin
        if (cpu_stat != STAT_AOK) state_nx = LD_STOP;
      end
      LD_STOP: begin
        if (ld_start) begin
          state_nx = LD_LOAD;
          count_nx = '0;
          ovf_nx   = 1'b0;
        end
      end
      default: state_nx = LD_IDLE;
    endcase
  end

  // ld_ready/cpu_run are flopped from the next state so they always equal the state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      load_count  <= '0;
      ld_overflow <= 1'b0;
      ld_ready    <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      state_q     <= state_nx;
      load_count  <= count_nx;
      ld_overflow <= ovf_nx;
      ld_ready    <= (state_nx == LD_LOAD);
      cpu_run     <= (state_nx == LD_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[load_count[ADDR_W-1:0]] <= ld_data;
  end

  assign state = state_q;

  imem_window #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_imem_window (
    .pc         (pc),
    .load_count (load_count),
    .mem        (mem),
    .instr      (instr),
    .imem_error (imem_error)
  );

endmodule
